bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Time-multiplexed seven-segment display driver for the packed BCD digit bus produced by the cascaded decimal counter chain. It takes a snapshot of all digits once per frame, which keeps every frame coherent while the counters ripple. It scans one digit at a time through common-anode/cathode select lines, decodes BCD to segments, and optionally blanks leading zeros. It sits between the counter chain and the board display pins.

## Interface
- NUM_DIGITS, 4: number of BCD digits and anode lines; must be ≥ 2.
- PRESCALE, 50000: clk cycles per digit slot; must be ≥ 2.
- ACTIVE_LOW, 1: when 1, `an`, `seg` and `dp` are inverted at the pins (0 = lit/selected).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; when 0, the prescaler and index hold and the display is dark.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k at [4k+3:4k], digit 0 = least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- blank_lz  in  1  leading-zero blanking enable.
- an  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW).
- seg  out  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW).
- dp  out  1  decimal point (polarity per ACTIVE_LOW).
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- State: prescaler `pcnt` (0..PRESCALE-1), digit index `idx` (0..NUM_DIGITS-1), shadow digit and dp registers, `first` flag.
- Reset:
  - pcnt=0, idx=0, shadow=0, first=1.
  - All outputs inactive: an none selected, seg all off, dp off, frame_tick=0.
- enable=1 advance rules:
  - pcnt increments each cycle.
  - When pcnt==PRESCALE-1, pcnt wraps to 0 and idx increments.
  - idx wraps from NUM_DIGITS-1 to 0.
- Snapshot: shadow ← digits_in/dp_in and frame_tick pulses in either of two cases:
  - the first enabled cycle after reset (first then clears);
  - the cycle where pcnt==PRESCALE-1 and idx==NUM_DIGITS-1.
- Deadtime: while pcnt==0, no anode is selected, to prevent ghosting. For pcnt 1..PRESCALE-1, an selects idx.
- Decode, shadow digit value → segments:
  - 0-9 → standard glyphs.
  - 10-15 → dash (g only).
  - dp output = shadow dp[idx].
- Leading-zero blanking: digit k is blanked (seg off, dp still honoured) when all of the following hold:
  - blank_lz=1;
  - digit k==0 and every digit above k ==0;
  - k≠0.
  - Digit 0 is never blanked.
- enable=0: pcnt, idx, shadow and first hold; outputs inactive next cycle. On re-enable, scanning resumes from the held pcnt/idx.
- reset has priority over enable at every cycle, including mid-frame. The display goes dark on the next edge.

## Timing
- All outputs are registered: they reflect the pcnt/idx/shadow values of the previous cycle (1-cycle latency).
- Per digit: PRESCALE-1 lit cycles + 1 dark cycle. Frame = NUM_DIGITS*PRESCALE cycles.
- digits_in changes mid-frame are invisible until the next snapshot; maximum staleness is one frame.
- frame_tick asserts the cycle after the snapshot condition, for exactly 1 cycle.

## Structure
- Shared package `display_pkg`:
  - BCD_W=4;
  - 7-bit glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high, gfedcba order).
- Sub-module `bcd_to_seg`: combinational 4-bit → 7-bit decoder using the package constants; instantiated once on the selected shadow digit.
- Polarity inversion is applied only at the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=4, ACTIVE_LOW=0.
- Reset then enable=1, digits_in=16'h1234 → frame_tick one cycle after the first enabled edge. Slot idx0: an=0001, seg=SEG_4 for 3 cycles, then 1 dark cycle; then idx1=SEG_3, idx2=SEG_2, idx3=SEG_1.
- Mid-frame change of digits_in from 16'h1234 to 16'h5678 while idx=1 → remaining slots still show 2,1. The next frame shows 8,7,6,5, with frame_tick at the wrap.
- blank_lz=1, digits_in=16'h0050 → idx3 and idx2 dark; idx1=SEG_5, idx0=SEG_0. digits_in=16'h0000 → only idx0 lit with SEG_0.
- Digit value 4'hB with dp_in=4'b0010 on idx1 → seg=SEG_DASH, dp=1 only during the idx1 slot.
- enable drops for 10 cycles at pcnt=2, idx=2 → outputs inactive next cycle. On re-enable, idx2 resumes for the remaining slot cycles.
- reset asserted mid-slot (idx=3) → next edge an=0, seg=0, frame_tick=0. After release, scanning restarts at idx0 with a fresh snapshot.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path.
// Glyphs are active-high in {g,f,e,d,c,b,a} order; any pin polarity
// inversion happens later, at the output registers of the scanner.
package display_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   i_bcd  BCD_W-bit digit value
//   o_seg  active-high segments {g,f,e,d,c,b,a}; values 10-15 show a dash
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment scanner for a packed BCD digit bus.
// Snapshots all digits once per frame so a frame is always coherent,
// scans one digit per PRESCALE-cycle slot (first cycle of each slot dark
// to avoid ghosting), and optionally blanks leading zeros.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   enable       scan enable; low holds the scan position and darkens outputs
//   digits_in    packed BCD, digit k at [4k+3:4k]
//   dp_in        decimal point request per digit
//   blank_lz     leading-zero blanking enable (digit 0 never blanked)
//   an, seg, dp  registered display pins, inverted when ACTIVE_LOW=1
//   frame_tick   one-cycle pulse following each snapshot
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_lz,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic                        frame_tick
);

  localparam int unsigned PCNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]             r_pcnt;
  logic [IDX_W-1:0]              r_idx;
  logic [BCD_W*NUM_DIGITS-1:0]   r_shadow;
  logic [NUM_DIGITS-1:0]         r_shadow_dp;
  logic                          r_first;
  logic [NUM_DIGITS-1:0]         r_an;
  logic [6:0]                    r_seg;
  logic                          r_dp;
  logic                          r_frame_tick;

  logic [BCD_W-1:0]      w_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_zero_above;
  logic                  w_run;
  logic [6:0]            w_seg_raw;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_blank;
  logic                  w_slot_end;
  logic                  w_snap;

  // w_zero_above[k]: digit k and every digit above it are zero.
  always_comb begin
    w_run        = 1'b1;
    w_zero_above = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      w_dig[k] = r_shadow[k*BCD_W +: BCD_W];
    end
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      w_run           = w_run & (w_dig[k] == '0);
      w_zero_above[k] = w_run;
    end
  end

  bcd_to_seg u_dec (
    .i_bcd (w_dig[r_idx]),
    .o_seg (w_seg_raw)
  );

  assign w_blank    = blank_lz && (r_idx != '0) && w_zero_above[r_idx];
  assign w_seg_nxt  = w_blank ? SEG_OFF : w_seg_raw;
  // pcnt==0 is the deadtime cycle of each slot
  assign w_an_nxt   = (r_pcnt != '0) ? (NUM_DIGITS'(1) << r_idx) : '0;
  assign w_slot_end = (r_pcnt == PCNT_LAST);
  assign w_snap     = enable && (r_first || (w_slot_end && r_idx == IDX_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_first      <= 1'b1;
      r_an         <= {NUM_DIGITS{ACTIVE_LOW}};
      r_seg        <= {7{ACTIVE_LOW}};
      r_dp         <= ACTIVE_LOW;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap;
      if (enable) begin
        if (w_slot_end) begin
          r_pcnt <= '0;
          r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
        if (w_snap) begin
          r_shadow    <= digits_in;
          r_shadow_dp <= dp_in;
          r_first     <= 1'b0;
        end
        r_an  <= w_an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
        r_seg <= w_seg_nxt ^ {7{ACTIVE_LOW}};
        r_dp  <= r_shadow_dp[r_idx] ^ ACTIVE_LOW;
      end else begin
        r_an  <= {NUM_DIGITS{ACTIVE_LOW}};
        r_seg <= {7{ACTIVE_LOW}};
        r_dp  <= ACTIVE_LOW;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with NUM_DIGITS=4, PRESCALE=4,
// ACTIVE_LOW=0. Outputs are sampled 1 time unit after each rising edge.
module tb_bcd_display_scan;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F,
                         S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07,
                         S8 = 7'h7F, S9 = 7'h6F, SD = 7'h40, SO = 7'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  bcd_display_scan #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n_lit lit cycles of digit idx, then the dark cycle that opens the next slot
  task automatic run_slot(input int idx, input logic [6:0] s, input logic d,
                          input logic ft_last, input int n_lit);
    for (int c = 0; c < n_lit; c++) begin
      step();
      check($sformatf("an_slot%0d", idx), 32'(an), 32'(1) << idx);
      check($sformatf("seg_slot%0d", idx), 32'(seg), 32'(s));
      check($sformatf("dp_slot%0d", idx), 32'(dp), 32'(d));
      check($sformatf("ft_slot%0d", idx), 32'(frame_tick), 32'(ft_last && (c == n_lit - 1)));
    end
    step();
    check($sformatf("an_dark%0d", idx), 32'(an), 32'(0));
    check($sformatf("ft_dark%0d", idx), 32'(frame_tick), 32'(0));
  endtask

  // Full frame; new inputs applied during slot 1 must not appear until next frame
  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps,
                           input logic [15:0] nd, input logic [3:0] ndp);
    run_slot(0, segs[6:0], dps[0], 1'b0, 3);
    digits_in = nd;
    dp_in     = ndp;
    for (int i = 1; i < 4; i++) begin
      run_slot(i, segs[7*i +: 7], dps[i], i == 3, 3);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    blank_lz  = 1'b0;
    repeat (3) step();
    check("rst_an", 32'(an), 32'(0));
    check("rst_seg", 32'(seg), 32'(0));
    check("rst_dp", 32'(dp), 32'(0));
    check("rst_ft", 32'(frame_tick), 32'(0));

    reset  = 1'b0;
    enable = 1'b1;
    step();
    check("first_ft", 32'(frame_tick), 32'(1));
    check("first_an", 32'(an), 32'(0));

    // 1234 shown; switch to 5678 mid-frame
    run_frame({S1, S2, S3, S4}, 4'b0000, 16'h5678, 4'b0000);
    run_frame({S5, S6, S7, S8}, 4'b0000, 16'h0050, 4'b0000);
    blank_lz = 1'b1;
    run_frame({SO, SO, S5, S0}, 4'b0000, 16'h0000, 4'b0000);
    run_frame({SO, SO, SO, S0}, 4'b0000, 16'h00B0, 4'b0010);
    blank_lz = 1'b0;
    run_frame({S0, S0, SD, S0}, 4'b0010, 16'h9876, 4'b0000);

    // enable drops at pcnt=2, idx=2
    run_slot(0, S6, 1'b0, 1'b0, 3);
    run_slot(1, S7, 1'b0, 1'b0, 3);
    step();
    check("pre_hold_an", 32'(an), 32'(4'b0100));
    check("pre_hold_seg", 32'(seg), 32'(S8));
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_an", 32'(an), 32'(0));
      check("hold_seg", 32'(seg), 32'(0));
      check("hold_ft", 32'(frame_tick), 32'(0));
    end
    enable = 1'b1;
    run_slot(2, S8, 1'b0, 1'b0, 2);
    run_slot(3, S9, 1'b0, 1'b1, 3);

    // reset mid-slot on idx3
    run_slot(0, S6, 1'b0, 1'b0, 3);
    run_slot(1, S7, 1'b0, 1'b0, 3);
    run_slot(2, S8, 1'b0, 1'b0, 3);
    step();
    check("pre_rst_an", 32'(an), 32'(4'b1000));
    check("pre_rst_seg", 32'(seg), 32'(S9));
    reset     = 1'b1;
    digits_in = 16'h1234;
    step();
    check("midrst_an", 32'(an), 32'(0));
    check("midrst_seg", 32'(seg), 32'(0));
    check("midrst_dp", 32'(dp), 32'(0));
    check("midrst_ft", 32'(frame_tick), 32'(0));
    reset = 1'b0;
    step();
    check("restart_ft", 32'(frame_tick), 32'(1));
    check("restart_an", 32'(an), 32'(0));
    run_frame({S1, S2, S3, S4}, 4'b0000, 16'h1234, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
